// File: rtl/hc_sr04_emulator_if.sv
// Controller-side signal bundle of the HC-SR04 emulator: trigger and distance in, echo and status out.
interface hc_sr04_emulator_if;
    logic        trig_in;
    logic [15:0] distance_mm;
    logic        echo_tx;
    logic        busy;
    logic        trig_err;
    logic [7:0]  meas_cnt;

    modport master (
        output trig_in,
        output distance_mm,
        input  echo_tx,
        input  busy,
        input  trig_err,
        input  meas_cnt
    );

    modport slave (
        input  trig_in,
        input  distance_mm,
        output echo_tx,
        output busy,
        output trig_err,
        output meas_cnt
    );
endinterface

// File: rtl/hc_sr04_emulator.sv
// HC-SR04 ultrasonic sensor emulator: validates the trigger width, then returns a distance-scaled echo.
// Optional macro HC_SR04_EMU_TIMEOUT_EN: out-of-range distances give a TIMEOUT_CYC-wide echo.
module hc_sr04_emulator #(
    parameter int unsigned TRIG_MIN    = 500,
    parameter int unsigned BURST_DLY   = 10000,
    parameter int unsigned CYC_PER_MM  = 290,
    parameter int unsigned MAX_MM      = 4000,
    parameter int unsigned TIMEOUT_CYC = 1900000,
    parameter int unsigned HOLDOFF_CYC = 500000
) (
    input  logic              clk_50M,
    input  logic              reset,
    hc_sr04_emulator_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StTrigHi, StBurst, StEcho, StHoldoff} state_e;

    state_e      state_q;
    logic        trig_s1_q, trig_s2_q, trig_prev_q;
    logic [24:0] cnt_q;
    logic [15:0] mm_q;
    logic        echo_q, busy_q, err_q;
    logic [7:0]  meas_q;

    logic        trig_rise, trig_fall, out_of_range;
    logic [24:0] echo_len;

    assign trig_rise    = trig_s2_q & ~trig_prev_q;
    assign trig_fall    = ~trig_s2_q & trig_prev_q;
    assign out_of_range = (mm_q == 16'd0) || (32'(mm_q) > MAX_MM);

`ifdef HC_SR04_EMU_TIMEOUT_EN
    localparam bit EchoOnOor = 1'b1;
    assign echo_len = out_of_range ? 25'(TIMEOUT_CYC) : 25'(mm_q) * 25'(CYC_PER_MM);
`else
    localparam bit EchoOnOor = 1'b0;
    assign echo_len = 25'(mm_q) * 25'(CYC_PER_MM);
`endif

    assign bus.echo_tx  = echo_q;
    assign bus.busy     = busy_q;
    assign bus.trig_err = err_q;
    assign bus.meas_cnt = meas_q;

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q     <= StIdle;
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_prev_q <= 1'b0;
            cnt_q       <= '0;
            mm_q        <= '0;
            echo_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            meas_q      <= '0;
        end else begin
            trig_s1_q   <= bus.trig_in;
            trig_s2_q   <= trig_s1_q;
            trig_prev_q <= trig_s2_q;
            err_q       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Edge-triggered only: a level still high after HOLDOFF is not a new trigger.
                    if (trig_rise) begin
                        state_q <= StTrigHi;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StTrigHi: begin
                    if (trig_fall) begin
                        cnt_q <= '0;
                        if (cnt_q >= 25'(TRIG_MIN)) begin
                            mm_q    <= bus.distance_mm;
                            state_q <= StBurst;
                        end else begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end else if (trig_s2_q && (cnt_q < 25'(TRIG_MIN))) begin
                        cnt_q <= cnt_q + 25'd1;
                    end
                end
                StBurst: begin
                    if (cnt_q == 25'(BURST_DLY - 1)) begin
                        cnt_q <= '0;
                        if (out_of_range && !EchoOnOor) begin
                            state_q <= StHoldoff;
                        end else begin
                            state_q <= StEcho;
                            echo_q  <= 1'b1;
                            meas_q  <= meas_q + 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 25'd1;
                    end
                end
                StEcho: begin
                    if (cnt_q == echo_len - 25'd1) begin
                        cnt_q   <= '0;
                        echo_q  <= 1'b0;
                        state_q <= StHoldoff;
                    end else begin
                        cnt_q <= cnt_q + 25'd1;
                    end
                end
                StHoldoff: begin
                    if (cnt_q == 25'(HOLDOFF_CYC - 1)) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 25'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    echo_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hc_sr04_emulator.sv
// Directed bench for hc_sr04_emulator; dut_a uses scaled timing, dut_b short timing for the wrap test.
module tb_hc_sr04_emulator;
    localparam int A_BURST   = 1000;
    localparam int A_CPM     = 290;
    localparam int A_TIMEOUT = 3000;
    localparam int A_HOLD    = 200;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #10 clk = ~clk;

    hc_sr04_emulator_if ifa ();
    hc_sr04_emulator_if ifb ();

    hc_sr04_emulator #(
        .TRIG_MIN(500), .BURST_DLY(A_BURST), .CYC_PER_MM(A_CPM), .MAX_MM(4000),
        .TIMEOUT_CYC(A_TIMEOUT), .HOLDOFF_CYC(A_HOLD)
    ) dut_a (
        .clk_50M(clk),
        .reset  (reset),
        .bus    (ifa)
    );

    hc_sr04_emulator #(
        .TRIG_MIN(4), .BURST_DLY(4), .CYC_PER_MM(3), .MAX_MM(4000),
        .TIMEOUT_CYC(50), .HOLDOFF_CYC(10)
    ) dut_b (
        .clk_50M(clk),
        .reset  (reset),
        .bus    (ifb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_a(input int hi);
        ifa.trig_in = 1'b1;
        repeat (hi) tick();
        ifa.trig_in = 1'b0;
    endtask

    task automatic pulse_b(input int hi);
        ifb.trig_in = 1'b1;
        repeat (hi) tick();
        ifb.trig_in = 1'b0;
    endtask

    // Counts sampled edges until echo_tx reaches lvl (or the bound runs out).
    task automatic wait_echo_a(input logic lvl, input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ifa.echo_tx !== lvl && n < bound);
    endtask

    task automatic wait_idle_a(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ifa.busy !== 1'b0 && n < bound);
    endtask

    initial begin
        int n, w, errs, echoes, busy0, busy_hi, exp_hi, exp_busy, exp_meas;

        reset           = 1'b1;
        ifa.trig_in     = 1'b0;
        ifa.distance_mm = 16'd0;
        ifb.trig_in     = 1'b0;
        ifb.distance_mm = 16'd0;
        exp_meas        = 0;
        repeat (5) tick();
        check("rst_echo", {31'd0, ifa.echo_tx}, 0);
        check("rst_busy", {31'd0, ifa.busy}, 0);
        check("rst_err", {31'd0, ifa.trig_err}, 0);
        check("rst_meas", {24'd0, ifa.meas_cnt}, 0);
        reset = 1'b0;
        repeat (5) tick();

        // Nominal 100 mm measurement; distance changes after the latch
        ifa.distance_mm = 16'd100;
        pulse_a(600);
        wait_echo_a(1'b1, 20000, n);
        check("t34_latency", n, A_BURST + 3);
        ifa.distance_mm = 16'd7;
        wait_echo_a(1'b0, 40000, n);
        check("t34_width", n, 100 * A_CPM);
        exp_meas++;
        check("t34_meas", {24'd0, ifa.meas_cnt}, exp_meas);
        check("t34_busy_holdoff", {31'd0, ifa.busy}, 1);
        wait_idle_a(1000, n);
        check("t34_holdoff", n, A_HOLD);

        // Short trigger is rejected
        ifa.distance_mm = 16'd100;
        pulse_a(499);
        errs = 0; echoes = 0; busy0 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ifa.trig_err === 1'b1) errs++;
            if (ifa.echo_tx === 1'b1) echoes++;
            if (busy0 == 0 && ifa.busy === 1'b0) busy0 = i;
        end
        check("t35_busy_low", busy0, 3);
        check("t35_err_pulses", errs, 1);
        check("t35_no_echo", echoes, 0);
        check("t35_meas", {24'd0, ifa.meas_cnt}, exp_meas);

        // Out-of-range distance
        ifa.distance_mm = 16'd5000;
        pulse_a(600);
`ifdef HC_SR04_EMU_TIMEOUT_EN
        exp_hi   = A_TIMEOUT;
        exp_busy = 3 + A_BURST + A_TIMEOUT + A_HOLD;
        exp_meas++;
`else
        exp_hi   = 0;
        exp_busy = 3 + A_BURST + A_HOLD;
`endif
        n = 0; w = 0;
        do begin
            tick();
            n++;
            if (ifa.echo_tx === 1'b1) w++;
        end while (ifa.busy !== 1'b0 && n < 10000);
        check("t36_echo_width", w, exp_hi);
        check("t36_busy_len", n, exp_busy);
        check("t36_meas", {24'd0, ifa.meas_cnt}, exp_meas);

        // Retrigger during ECHO is ignored
        ifa.distance_mm = 16'd20;
        pulse_a(600);
        wait_echo_a(1'b1, 20000, n);
        check("t37_latency", n, A_BURST + 3);
        w = 1; errs = 0;
        for (int i = 0; i < 20000; i++) begin
            if (i == 100) ifa.trig_in = 1'b1;
            if (i == 700) ifa.trig_in = 1'b0;
            tick();
            if (ifa.echo_tx === 1'b1) w++;
            if (ifa.trig_err === 1'b1) errs++;
            if (ifa.busy !== 1'b1) break;
        end
        check("t37_width", w, 20 * A_CPM);
        check("t37_no_err", errs, 0);
        exp_meas++;
        check("t37_meas", {24'd0, ifa.meas_cnt}, exp_meas);
        busy_hi = 0;
        repeat (50) begin
            tick();
            if (ifa.busy !== 1'b0) busy_hi++;
        end
        check("t37_no_restart", busy_hi, 0);

        // Reset 1000 cycles into ECHO
        ifa.distance_mm = 16'd10;
        pulse_a(600);
        wait_echo_a(1'b1, 20000, n);
        repeat (1000) tick();
        reset = 1'b1;
        tick();
        check("t38_rst_echo", {31'd0, ifa.echo_tx}, 0);
        check("t38_rst_busy", {31'd0, ifa.busy}, 0);
        check("t38_rst_err", {31'd0, ifa.trig_err}, 0);
        check("t38_rst_meas", {24'd0, ifa.meas_cnt}, 0);
        repeat (2) tick();
        reset = 1'b0;
        exp_meas = 0;
        echoes = 0; busy_hi = 0;
        repeat (20) begin
            tick();
            if (ifa.echo_tx !== 1'b0) echoes++;
            if (ifa.busy !== 1'b0) busy_hi++;
        end
        check("t38_no_partial_echo", echoes, 0);
        check("t38_idle_after_rst", busy_hi, 0);
        pulse_a(600);
        wait_echo_a(1'b1, 20000, n);
        check("t38_latency", n, A_BURST + 3);
        wait_echo_a(1'b0, 20000, n);
        check("t38_width", n, 10 * A_CPM);
        exp_meas++;
        check("t38_meas", {24'd0, ifa.meas_cnt}, exp_meas);
        wait_idle_a(1000, n);

        // 256 short measurements on dut_b wrap meas_cnt
        ifb.distance_mm = 16'd1;
        for (int k = 1; k <= 256; k++) begin
            pulse_b(8);
            n = 0;
            do begin
                tick();
                n++;
            end while (ifb.busy !== 1'b0 && n < 200);
            if (k == 1) check("t39_busy_len", n, 3 + 4 + 3 + 10);
            if (k == 255) check("t39_meas_255", {24'd0, ifb.meas_cnt}, 255);
        end
        check("t39_meas_wrap", {24'd0, ifb.meas_cnt}, 0);

        // Trigger held high across the end of HOLDOFF must not start a new cycle
        pulse_b(8);
        repeat (10) tick();
        ifb.trig_in = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (ifb.busy !== 1'b0 && n < 100);
        busy_hi = 0; errs = 0;
        repeat (30) begin
            tick();
            if (ifb.busy !== 1'b0) busy_hi++;
            if (ifb.trig_err !== 1'b0) errs++;
        end
        ifb.trig_in = 1'b0;
        repeat (10) begin
            tick();
            if (ifb.busy !== 1'b0) busy_hi++;
            if (ifb.trig_err !== 1'b0) errs++;
        end
        check("t27_no_accept", busy_hi, 0);
        check("t27_no_err", errs, 0);
        check("t27_meas", {24'd0, ifb.meas_cnt}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hc_sr04_emulator.md
HC_SR04_EMULATOR -- requirements
Module: hc_sr04_emulator

Interface
REQ-001 The block SHALL have parameter TRIG_MIN, default 500, the minimum trigger-high length in clk_50M cycles (10 us).
REQ-002 The block SHALL have parameter BURST_DLY, default 10000, the cycles from accepted trigger fall to echo rise (200 us).
REQ-003 The block SHALL have parameter CYC_PER_MM, default 290, the echo-high cycles per mm of distance.
REQ-004 The block SHALL have parameter MAX_MM, default 4000, the largest in-range distance in mm.
REQ-005 The block SHALL have parameter TIMEOUT_CYC, default 1900000, the no-object echo width (38 ms).
REQ-006 The block SHALL have parameter HOLDOFF_CYC, default 500000, the dead time after echo fall (10 ms).
REQ-007 The block SHALL have port clk_50M, input, 1 bit: the 50 MHz system clock; there is one clock.
REQ-008 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-009 The block SHALL have port trig_in, input, 1 bit: trigger from the controller, asynchronous.
REQ-010 The block SHALL have port distance_mm, input, 16 bits: the simulated target distance.
REQ-011 The block SHALL have port echo_tx, output, 1 bit: the echo pulse to the controller.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port trig_err, output, 1 bit: a one-cycle pulse when a trigger is rejected as too short.
REQ-014 The block SHALL have port meas_cnt, output, 8 bits: the count of echoes issued, wrapping 255 -> 0.

Function
REQ-015 trig_in SHALL pass through a 2-flop synchroniser; a rise or fall is detected on the synchronised signal versus its previous value.
REQ-016 The FSM SHALL have states IDLE, TRIG_HI, BURST, ECHO and HOLDOFF.
REQ-017 In IDLE, a synchronised rise SHALL go to TRIG_HI and clear the high-length counter.
REQ-018 In TRIG_HI, the counter SHALL increment each cycle while trig is high, saturating at TRIG_MIN.
REQ-019 On a fall in TRIG_HI with count >= TRIG_MIN, the block SHALL latch distance_mm and go to BURST.
REQ-020 On a fall in TRIG_HI with count < TRIG_MIN, the block SHALL pulse trig_err for 1 cycle and return to IDLE.
REQ-021 BURST SHALL last exactly BURST_DLY cycles; echo_tx SHALL rise on the first ECHO cycle.
REQ-022 Echo width SHALL be latched_mm*CYC_PER_MM cycles, computed at full 25-bit width with no truncation.
REQ-023 If latched_mm == 0 or latched_mm > MAX_MM, the distance is out of range; see REQ-032/033.
REQ-024 meas_cnt SHALL increment on the cycle echo_tx rises.
REQ-025 After echo_tx falls, the block SHALL stay in HOLDOFF for HOLDOFF_CYC cycles, then return to IDLE.
REQ-026 Trigger edges in BURST, ECHO and HOLDOFF SHALL be ignored, with no trig_err and no restart.
REQ-027 A trigger still high when HOLDOFF ends SHALL NOT be accepted until it falls and rises again.
REQ-028 A change in distance_mm after the latch SHALL NOT affect the echo in flight.

Reset
REQ-029 While reset is high at a clk_50M edge, state SHALL become IDLE and echo_tx, busy, trig_err and meas_cnt SHALL become 0.
REQ-030 Reset SHALL also clear all counters, the synchroniser flops and the latched distance.
REQ-031 Reset asserted mid-ECHO SHALL drive echo_tx low on the next edge, with no partial-pulse completion after release.

Configuration
REQ-032 With macro HC_SR04_EMU_TIMEOUT_EN defined, an out-of-range distance SHALL produce an echo exactly TIMEOUT_CYC cycles wide, followed by HOLDOFF.
REQ-033 Without HC_SR04_EMU_TIMEOUT_EN, an out-of-range distance SHALL produce no echo: BURST goes directly to HOLDOFF and meas_cnt is unchanged.

Verification
REQ-034 Bench: trig high 600 cycles, distance_mm=100 -> echo rises 10000 cycles after the synchronised fall, stays high 29000 cycles, meas_cnt=1.
REQ-035 Bench: trig high 499 cycles -> one trig_err pulse, echo_tx stays 0, busy returns to 0 after 3 cycles.
REQ-036 Bench: distance_mm=5000 with macro -> echo high 1900000 cycles; without macro -> no echo and meas_cnt unchanged.
REQ-037 Bench: second trig (600 cycles) during ECHO -> ignored, echo width unchanged, no trig_err.
REQ-038 Bench: reset pulsed 1000 cycles into ECHO -> echo_tx=0 on the next edge and all outputs 0; a new 600-cycle trig then yields a normal echo.
REQ-039 Bench: 256 valid measurements at distance_mm=1 with HOLDOFF_CYC overridden to 10 -> meas_cnt wraps to 0.
